// File: rtl/uart_receiver_if.sv
// Serial-side and byte-side signals of the UART receiver, bundled for port hookup.
// The slave modport is the receiver; the master modport drives the line and tick.
interface uart_receiver_if;
  logic       i_CLK_ENABLE;
  logic       i_RX;
  logic [7:0] o_DATA_OUT;
  logic       o_RX_VALID;
  logic       o_FRAME_ERROR;
  logic       o_RX_BUSY;

  modport slave (
    input  i_CLK_ENABLE,
    input  i_RX,
    output o_DATA_OUT,
    output o_RX_VALID,
    output o_FRAME_ERROR,
    output o_RX_BUSY
  );

  modport master (
    output i_CLK_ENABLE,
    output i_RX,
    input  o_DATA_OUT,
    input  o_RX_VALID,
    input  o_FRAME_ERROR,
    input  o_RX_BUSY
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver driven by an external oversample tick; samples each bit at
// its centre and reports a good byte or a framing error with one-cycle pulses.
module uart_receiver #(
  parameter int p_OVERSAMPLE = 16
) (
  input logic            i_CLK,
  input logic            i_RESET,
  uart_receiver_if.slave bus
);

  localparam int TW = $clog2(p_OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(p_OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(p_OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {s_IDLE, s_START, s_DATA, s_STOP} state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] tick_cnt_reg, tick_cnt_next;
  logic [3:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic [7:0]    data_reg, data_next;
  logic          valid_reg, valid_next;
  logic          ferr_reg, ferr_next;
  logic          busy_reg;
  logic [1:0]    sync_reg;
  logic          rx_s;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], bus.i_RX};
    end
  end

  assign rx_s = sync_reg[1];

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_reg    <= s_IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      ferr_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      ferr_reg     <= ferr_next;
      busy_reg     <= (state_reg != s_IDLE);
    end
  end

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    data_next     = data_reg;
    valid_next    = 1'b0;
    ferr_next     = 1'b0;

    if (bus.i_CLK_ENABLE) begin
      unique case (state_reg)
        s_IDLE: begin
          if (!rx_s) begin
            state_next    = s_START;
            tick_cnt_next = '0;
          end
        end
        // Re-check the line half a bit in to reject glitches as false starts.
        s_START: begin
          if (tick_cnt_reg == TICK_MID) begin
            tick_cnt_next = '0;
            bit_cnt_next  = '0;
            state_next    = rx_s ? s_IDLE : s_DATA;
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
        s_DATA: begin
          if (tick_cnt_reg == TICK_LAST) begin
            tick_cnt_next = '0;
            shift_next    = {rx_s, shift_reg[7:1]};
            bit_cnt_next  = bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 4'd7) begin
              state_next = s_STOP;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
        s_STOP: begin
          if (tick_cnt_reg == TICK_LAST) begin
            tick_cnt_next = '0;
            state_next    = s_IDLE;
            if (rx_s) begin
              data_next  = shift_reg;
              valid_next = 1'b1;
            end else begin
              ferr_next  = 1'b1;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
        default: state_next = s_IDLE;
      endcase
    end
  end

  assign bus.o_DATA_OUT    = data_reg;
  assign bus.o_RX_VALID    = valid_reg;
  assign bus.o_FRAME_ERROR = ferr_reg;
  assign bus.o_RX_BUSY     = busy_reg;

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter p_OVERSAMPLE, default 16, giving i_CLK_ENABLE ticks per bit period; legal values are even integers 4..16.
REQ-002 The block SHALL have port i_CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_RESET, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port i_CLK_ENABLE, input, 1 bit: oversample tick, one i_CLK cycle wide, at p_OVERSAMPLE x baud, generated externally.
REQ-005 The block SHALL have port i_RX, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 The block SHALL have port o_DATA_OUT, output, 8 bits: last correctly framed byte received.
REQ-007 The block SHALL have port o_RX_VALID, output, 1 bit: one-i_CLK-cycle pulse when o_DATA_OUT is updated.
REQ-008 The block SHALL have port o_FRAME_ERROR, output, 1 bit: one-i_CLK-cycle pulse when the stop bit is sampled low.
REQ-009 The block SHALL have port o_RX_BUSY, output, 1 bit: high while the FSM is not in s_IDLE.

Function
REQ-010 i_RX SHALL pass through a 2-flop synchronizer, with both flops reset to 1; all sampling SHALL use the synchronizer output (rx_s).
REQ-011 The FSM SHALL have states s_IDLE, s_START, s_DATA and s_STOP, a tick counter 0..p_OVERSAMPLE-1 and a bit counter 0..8; counters and state SHALL advance only in cycles with i_CLK_ENABLE=1.
REQ-012 In s_IDLE, a tick with rx_s=0 SHALL move to s_START and clear the tick counter; otherwise the FSM SHALL stay in s_IDLE.
REQ-013 In s_START, the tick counter SHALL increment each tick; at count p_OVERSAMPLE/2-1, rx_s=0 SHALL move to s_DATA with both counters cleared, and rx_s=1 SHALL return to s_IDLE as a false start with no output pulse.
REQ-014 In s_DATA, at tick count p_OVERSAMPLE-1 the block SHALL shift rx_s into the MSB of an 8-bit shift register (right shift), increment the bit counter and clear the tick counter; after the 8th sample it SHALL move to s_STOP.
REQ-015 In s_STOP, at tick count p_OVERSAMPLE-1 the block SHALL sample rx_s and return to s_IDLE.
REQ-016 A stop sample of 1 SHALL load o_DATA_OUT from the shift register and assert o_RX_VALID in the next i_CLK cycle only.
REQ-017 A stop sample of 0 SHALL assert o_FRAME_ERROR in the next i_CLK cycle only and leave o_DATA_OUT unchanged.
REQ-018 o_RX_VALID and o_FRAME_ERROR SHALL never be high in the same cycle; both SHALL be low in every other cycle, regardless of i_CLK_ENABLE.
REQ-019 o_RX_BUSY SHALL be registered: high from the cycle after entry to s_START until the cycle after return to s_IDLE.
REQ-020 After s_STOP the FSM SHALL accept a new start bit on the very next tick (back-to-back frames, one stop bit).
REQ-021 A line held low (break) SHALL produce repeated frames of 0x00 each ending in an o_FRAME_ERROR pulse; no other break handling is required.
REQ-022 Ticks arriving while i_CLK_ENABLE=0 SHALL have no effect; the block SHALL not require a fixed tick spacing.

Reset
REQ-023 When i_RESET=1 at a rising edge, the block SHALL go to s_IDLE, clear both counters and the shift register, set the synchronizer to 1, and drive o_DATA_OUT=0x00, o_RX_VALID=0, o_FRAME_ERROR=0 and o_RX_BUSY=0, regardless of i_CLK_ENABLE.
REQ-024 A reset mid-frame SHALL abort the frame with no pulse, and the next frame SHALL be received normally.

Verification (p_OVERSAMPLE=16, i_CLK_ENABLE tied 1 unless stated)
REQ-025 Frame 0x55 at 16 cycles/bit -> o_DATA_OUT=0x55, o_RX_VALID high exactly 1 cycle, o_FRAME_ERROR=0, o_RX_BUSY low afterwards.
REQ-026 i_RX low for 4 cycles, then high -> return to s_IDLE, no o_RX_VALID or o_FRAME_ERROR pulse, o_DATA_OUT unchanged.
REQ-027 After 0x55, frame 0xA3 with stop bit 0 -> o_FRAME_ERROR pulses 1 cycle, o_DATA_OUT stays 0x55.
REQ-028 i_RESET pulsed during data bit 4 of 0xC6, then clean frame 0x0F -> no pulse for the aborted frame, o_DATA_OUT=0x00 after reset, then 0x0F with one valid pulse.
REQ-029 Back-to-back frames 0x00, 0xFF with no idle gap -> two o_RX_VALID pulses 160 cycles apart with the correct data.
REQ-030 i_CLK_ENABLE at 1-in-5 cycles with frame 0x81 timed to 80 cycles/bit -> o_DATA_OUT=0x81 and o_RX_VALID exactly 1 i_CLK cycle wide.
